dm_bus_bridge: RTL and testbench

//  Memory-stage bridge between the multi-cycle CPU's data-memory access (ALU-register address, B-register store data)
//  and a variable-latency 32-bit word memory with ready handshake. Converts one CPU request into one memory transaction.

---
 rtl/dm_bus_bridge.sv | 119 +++++++++++
 tb/tb_dm_bus_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_bridge.sv
// Data-memory bridge: turns one CPU load/store request into one word-memory
// transaction, with byte lanes, lb sign extension and error/timeout reporting.
module dm_bus_bridge #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_byte,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rdy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic        r_byte;
   logic [1:0]  r_lane;
   logic [7:0]  r_cnt;

   logic        w_bad;
   logic        w_cnt_hit;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_lane_byte;
   logic [31:0] w_load_data;

   always_comb begin
      w_bad       = (!cpu_byte && (cpu_addr[1:0] != 2'b00)) ||
                    (cpu_addr[31:ADDR_W+2] != '0);
      // r_cnt counts completed miss cycles, so the TIMEOUT-th miss sees TIMEOUT-1
      w_cnt_hit   = (r_cnt == 8'(TIMEOUT - 1));
      w_be        = cpu_byte ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
      w_wdata     = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
      w_lane_byte = mem_rdata[{r_lane, 3'b000} +: 8];
      w_load_data = r_byte ? {{24{w_lane_byte[7]}}, w_lane_byte} : mem_rdata;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cpu_req) w_next = w_bad ? S_ERR : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (mem_rdy)        w_next = S_RESP;
            else if (w_cnt_hit) w_next = S_ERR;
         end
         S_RESP:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_byte    <= 1'b0;
         r_lane    <= 2'b00;
         r_cnt     <= '0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         r_state <= w_next;
         // Outputs are registered from the next state so they line up with it
         mem_cs  <= (w_next == S_ISSUE);
         cpu_ack <= (w_next == S_RESP) || (w_next == S_ERR);
         cpu_err <= (w_next == S_ERR);

         if (r_state == S_IDLE && cpu_req) begin
            r_we   <= cpu_we;
            r_byte <= cpu_byte;
            r_lane <= cpu_addr[1:0];
         end

         if (r_state == S_IDLE && w_next == S_ISSUE) begin
            mem_we    <= cpu_we;
            mem_be    <= w_be;
            mem_addr  <= cpu_addr[ADDR_W+1:2];
            mem_wdata <= w_wdata;
         end

         if (r_state == S_ISSUE)
            r_cnt <= '0;
         else if (r_state == S_WAIT && !mem_rdy)
            r_cnt <= r_cnt + 8'd1;

         if (r_state == S_WAIT && mem_rdy && !r_we)
            cpu_rdata <= w_load_data;
      end
   end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Directed self-checking bench for dm_bus_bridge.
module tb_dm_bus_bridge;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_byte;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_ack;
   logic              cpu_err;
   logic              mem_cs;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_rdy;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations from the last access
   int                o_cs_cnt;
   logic [ADDR_W-1:0] o_cs_addr;
   logic [3:0]        o_cs_be;
   logic              o_cs_we;
   logic [31:0]       o_cs_wdata;
   int                o_ack_k;
   int                o_ack_cnt;
   logic              o_err;
   int                o_err_stray;
   logic [31:0]       o_rdata;

   dm_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_byte  (cpu_byte),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy)
   );

   always #5 clk = ~clk;

   // Issues one request; mem_rdy is high only for the edge T+rdy_k (0 = never).
   // Observation k is taken between edges T+k-1 and T+k.
   task automatic run_access(input logic we, input logic byt, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int rdy_k);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_byte  = byt;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      mem_rdata = rdata;
      mem_rdy   = 1'b0;
      o_cs_cnt = 0; o_ack_k = 0; o_ack_cnt = 0; o_err = 1'b0; o_err_stray = 0;
      o_cs_addr = '0; o_cs_be = '0; o_cs_we = 1'b0; o_cs_wdata = '0; o_rdata = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mem_cs) begin
            o_cs_cnt++;
            o_cs_addr  = mem_addr;
            o_cs_be    = mem_be;
            o_cs_we    = mem_we;
            o_cs_wdata = mem_wdata;
         end
         if (cpu_ack) begin
            o_ack_cnt++;
            if (o_ack_k == 0) begin
               o_ack_k = k;
               o_err   = cpu_err;
               o_rdata = cpu_rdata;
               cpu_req = 1'b0;
            end
         end
         if (cpu_err && !cpu_ack) o_err_stray++;
         mem_rdy = (k == rdy_k);
         if (o_ack_k != 0 && k >= o_ack_k + 3) break;
      end
      cpu_req = 1'b0;
      mem_rdy = 1'b0;
   endtask

   task automatic test_reset;
      logic [ADDR_W+70:0] obs;
      rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
      cpu_addr = 32'h10; cpu_wdata = 32'h5A5A5A5A; mem_rdata = 32'hFFFFFFFF; mem_rdy = 1'b1;
      for (int e = 0; e < 2; e++) begin
         @(negedge clk);
         obs = {cpu_rdata, cpu_ack, cpu_err, mem_cs, mem_we, mem_be, mem_addr, mem_wdata};
         n_checks++;
         if (obs !== '0) $display("FAIL reset_outputs_%0d: got %h, want 0", e, obs);
         else n_pass++;
      end
      rst = 1'b1; cpu_req = 1'b0; mem_rdy = 1'b0;
   endtask

   task automatic test_lw;
      run_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 2);
      n_checks++; if (o_cs_cnt !== 1) $display("FAIL lw_cs_count: got %0d, want 1", o_cs_cnt); else n_pass++;
      n_checks++; if (o_cs_addr !== 10'd4) $display("FAIL lw_addr: got %h, want 004", o_cs_addr); else n_pass++;
      n_checks++; if (o_cs_be !== 4'b1111) $display("FAIL lw_be: got %b, want 1111", o_cs_be); else n_pass++;
      n_checks++; if (o_cs_we !== 1'b0) $display("FAIL lw_we: got %b, want 0", o_cs_we); else n_pass++;
      n_checks++; if (o_ack_k !== 3) $display("FAIL lw_ack_latency: got %0d, want 3", o_ack_k); else n_pass++;
      n_checks++; if (o_err !== 1'b0) $display("FAIL lw_err: got %b, want 0", o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h, want deadbeef", o_rdata); else n_pass++;
      n_checks++; if (o_ack_cnt !== 1) $display("FAIL lw_ack_pulse: got %0d cycles, want 1", o_ack_cnt); else n_pass++;
   endtask

   task automatic test_byte;
      run_access(1'b1, 1'b1, 32'h0000_0023, 32'h0000_0081, 32'h0, 2);
      n_checks++; if (o_cs_addr !== 10'd8) $display("FAIL sb_addr: got %h, want 008", o_cs_addr); else n_pass++;
      n_checks++; if (o_cs_be !== 4'b1000) $display("FAIL sb_be: got %b, want 1000", o_cs_be); else n_pass++;
      n_checks++; if (o_cs_wdata !== 32'h81818181) $display("FAIL sb_wdata: got %h, want 81818181", o_cs_wdata); else n_pass++;
      n_checks++; if (o_cs_we !== 1'b1) $display("FAIL sb_we: got %b, want 1", o_cs_we); else n_pass++;
      n_checks++; if (o_ack_k !== 3 || o_err !== 1'b0) $display("FAIL sb_ack: got k=%0d err=%b, want k=3 err=0", o_ack_k, o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL sb_rdata_kept: got %h, want deadbeef", o_rdata); else n_pass++;

      run_access(1'b0, 1'b1, 32'h0000_0023, 32'h0, 32'h81000000, 2);
      n_checks++; if (o_cs_be !== 4'b1000 || o_cs_we !== 1'b0) $display("FAIL lb3_be_we: got be=%b we=%b, want 1000/0", o_cs_be, o_cs_we); else n_pass++;
      n_checks++; if (o_rdata !== 32'hFFFFFF81) $display("FAIL lb3_rdata: got %h, want ffffff81", o_rdata); else n_pass++;

      run_access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h12345678, 2);
      n_checks++; if (o_rdata !== 32'h00000078) $display("FAIL lb0_rdata: got %h, want 00000078", o_rdata); else n_pass++;

      run_access(1'b0, 1'b1, 32'h0000_0021, 32'h0, 32'h0000F000, 2);
      n_checks++; if (o_cs_be !== 4'b0010) $display("FAIL lb1_be: got %b, want 0010", o_cs_be); else n_pass++;
      n_checks++; if (o_rdata !== 32'hFFFFFFF0) $display("FAIL lb1_rdata: got %h, want fffffff0", o_rdata); else n_pass++;
   endtask

   task automatic test_errors;
      run_access(1'b0, 1'b0, 32'h0000_0006, 32'h0, 32'h11111111, 2);
      n_checks++; if (o_cs_cnt !== 0) $display("FAIL misalign_cs: got %0d, want 0", o_cs_cnt); else n_pass++;
      n_checks++; if (o_ack_k !== 1 || o_err !== 1'b1) $display("FAIL misalign_ack: got k=%0d err=%b, want k=1 err=1", o_ack_k, o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'hFFFFFFF0) $display("FAIL misalign_rdata_kept: got %h, want fffffff0", o_rdata); else n_pass++;
      n_checks++; if (o_ack_cnt !== 1 || o_err_stray !== 0) $display("FAIL misalign_pulse: got ack=%0d stray_err=%0d, want 1/0", o_ack_cnt, o_err_stray); else n_pass++;

      run_access(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h11111111, 2);
      n_checks++; if (o_cs_cnt !== 0) $display("FAIL range_cs: got %0d, want 0", o_cs_cnt); else n_pass++;
      n_checks++; if (o_ack_k !== 1 || o_err !== 1'b1) $display("FAIL range_ack: got k=%0d err=%b, want k=1 err=1", o_ack_k, o_err); else n_pass++;

      run_access(1'b1, 1'b0, 32'h0000_0002, 32'hCAFEF00D, 32'h0, 2);
      n_checks++; if (o_cs_cnt !== 0 || o_ack_k !== 1 || o_err !== 1'b1) $display("FAIL sw_misalign: got cs=%0d k=%0d err=%b, want 0/1/1", o_cs_cnt, o_ack_k, o_err); else n_pass++;
   endtask

   task automatic test_timeout;
      run_access(1'b0, 1'b0, 32'h0000_0FFC, 32'h0, 32'h22222222, 0);
      n_checks++; if (o_cs_cnt !== 1 || o_cs_addr !== 10'h3FF) $display("FAIL to_cs: got cs=%0d addr=%h, want 1/3ff", o_cs_cnt, o_cs_addr); else n_pass++;
      n_checks++; if (o_ack_k !== TIMEOUT + 2 || o_err !== 1'b1) $display("FAIL to_err: got k=%0d err=%b, want k=%0d err=1", o_ack_k, o_err, TIMEOUT + 2); else n_pass++;
      n_checks++; if (o_rdata !== 32'hFFFFFFF0) $display("FAIL to_rdata_kept: got %h, want fffffff0", o_rdata); else n_pass++;

      run_access(1'b0, 1'b0, 32'h0000_0FFC, 32'h0, 32'h33333333, TIMEOUT + 1);
      n_checks++; if (o_ack_k !== TIMEOUT + 2 || o_err !== 1'b0) $display("FAIL to_edge_ack: got k=%0d err=%b, want k=%0d err=0", o_ack_k, o_err, TIMEOUT + 2); else n_pass++;
      n_checks++; if (o_rdata !== 32'h33333333) $display("FAIL to_edge_rdata: got %h, want 33333333", o_rdata); else n_pass++;

      // mem_rdy during ISSUE is not a completion
      run_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h44444444, 1);
      n_checks++; if (o_ack_k !== TIMEOUT + 2 || o_err !== 1'b1) $display("FAIL issue_rdy_ignored: got k=%0d err=%b, want k=%0d err=1", o_ack_k, o_err, TIMEOUT + 2); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int acks = 0;
      int errs = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'h55555555; mem_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; cpu_req = 1'b0; mem_rdy = 1'b1;
      n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL midrst_rdata: got %h, want 0", cpu_rdata); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mem_rdy = 1'b0;
         if (cpu_ack) acks++;
         if (cpu_err) errs++;
      end
      n_checks++; if (acks !== 0 || errs !== 0) $display("FAIL midrst_no_ack: got ack=%0d err=%0d, want 0/0", acks, errs); else n_pass++;

      run_access(1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0BADF00D, 3);
      n_checks++; if (o_ack_k !== 4 || o_err !== 1'b0) $display("FAIL midrst_next_ack: got k=%0d err=%b, want k=4 err=0", o_ack_k, o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'h0BADF00D || o_cs_addr !== 10'h011) $display("FAIL midrst_next_data: got %h @%h, want 0badf00d @011", o_rdata, o_cs_addr); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_byte();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
